uart_cfg_if: RTL and testbench

UART_CFG_IF -- requirements
Module: uart_cfg_if

---
 rtl/uart_pkg.sv | 52 +++++
 rtl/uart_bit_timer.sv | 40 ++++
 rtl/uart_cfg_if.sv | 198 +++++++++++++++++++
 tb/tb_uart_cfg_if.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the UART configuration interface.
package uart_pkg;

  localparam int MIN_DIV = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_EVEN  = 2'b01,
    PAR_ODD   = 2'b10,
    PAR_NONE2 = 2'b11
  } parity_e;

  typedef enum logic [1:0] {
    BITS_5 = 2'b00,
    BITS_6 = 2'b01,
    BITS_7 = 2'b10,
    BITS_8 = 2'b11
  } data_bits_e;

  function automatic logic [3:0] bits_num(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

  function automatic logic [7:0] bits_mask(input logic [1:0] code);
    logic [7:0] m;
    case (data_bits_e'(code))
      BITS_5:  m = 8'h1F;
      BITS_6:  m = 8'h3F;
      BITS_7:  m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic par_en(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // RX shifts bits in at the MSB, so the frame sits in the top N bits.
  function automatic logic [7:0] rx_align(input logic [7:0] sh, input logic [1:0] code);
    return sh >> (4'd8 - bits_num(code));
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: latches D (floored at MIN_DIV) on load, counts 0..D-1 and wraps.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CNT_BITWIDTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load,
  input  logic                    i_run,
  input  logic [CNT_BITWIDTH-1:0] i_div,
  output logic                    o_mid,
  output logic                    o_end
);

  localparam logic [CNT_BITWIDTH-1:0] L_MIN_DIV = CNT_BITWIDTH'(MIN_DIV);

  logic [CNT_BITWIDTH-1:0] r_div;
  logic [CNT_BITWIDTH-1:0] r_cnt;
  logic [CNT_BITWIDTH-1:0] w_div_eff;
  logic                    w_last;

  assign w_div_eff = (i_div < L_MIN_DIV) ? L_MIN_DIV : i_div;
  assign w_last    = (r_cnt == r_div - 1'b1);
  assign o_mid     = i_run && (r_cnt == (r_div >> 1));
  assign o_end     = i_run && w_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div <= L_MIN_DIV;
      r_cnt <= '0;
    end else if (i_load) begin
      r_div <= w_div_eff;
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cfg_if.sv
// Configurable UART with RTS/CTS flow control; frame settings are captured at each frame start.
// state     | meaning
// IDLE      | line idle, waiting for accept (TX) or falling edge (RX)
// START     | start bit
// DATA      | N data bits, LSB first
// PARITY    | optional parity bit
// STOP      | one or two stop bits (RX samples only the first)
module uart_cfg_if
  import uart_pkg::*;
#(
  parameter int CNT_BITWIDTH = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [CNT_BITWIDTH-1:0] div_i,
  input  logic [1:0]              data_bits_i,
  input  logic [1:0]              parity_i,
  input  logic                    stop2_i,
  input  logic                    uart_rx_i,
  output logic                    uart_cts_o,
  output logic                    uart_tx_o,
  input  logic                    uart_rts_i,
  output logic                    rx_valid_o,
  output logic [7:0]              rx_data_o,
  output logic                    rx_parity_err_o,
  output logic                    rx_frame_err_o,
  input  logic                    rx_hold_i,
  input  logic                    tx_valid_i,
  input  logic [7:0]              tx_data_i,
  output logic                    tx_ready_o
);

  uart_state_e r_tx_state, w_tx_next;
  logic [7:0]  r_tx_shift;
  logic [3:0]  r_tx_bit;
  logic [1:0]  r_tx_bits;
  logic        r_tx_par_en, r_tx_par, r_tx_stop2, r_tx_stop_cnt;
  logic        w_tx_ready, w_tx_accept, w_tx_end, w_tx_line;
  logic        w_tx_mid_unused;  // TX only needs the end-of-bit strobe
  logic [3:0]  w_tx_last_bit;

  assign uart_cts_o    = ~rx_hold_i;
  assign w_tx_ready    = (r_tx_state == ST_IDLE) && uart_rts_i && !rst_i;
  assign w_tx_accept   = w_tx_ready && tx_valid_i;
  assign tx_ready_o    = w_tx_ready;
  assign uart_tx_o     = w_tx_line;
  assign w_tx_last_bit = bits_num(r_tx_bits) - 4'd1;

  uart_bit_timer #(.CNT_BITWIDTH(CNT_BITWIDTH)) u_tx_timer (
    .i_clk  (clk_i),
    .i_rst  (rst_i),
    .i_load (w_tx_accept),
    .i_run  (r_tx_state != ST_IDLE),
    .i_div  (div_i),
    .o_mid  (w_tx_mid_unused),
    .o_end  (w_tx_end)
  );

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_line = 1'b1;
    case (r_tx_state)
      ST_IDLE:   if (w_tx_accept) w_tx_next = ST_START;
      ST_START: begin
        w_tx_line = 1'b0;
        if (w_tx_end) w_tx_next = ST_DATA;
      end
      ST_DATA: begin
        w_tx_line = r_tx_shift[0];
        if (w_tx_end && (r_tx_bit == w_tx_last_bit))
          w_tx_next = r_tx_par_en ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        w_tx_line = r_tx_par;
        if (w_tx_end) w_tx_next = ST_STOP;
      end
      ST_STOP:   if (w_tx_end && (!r_tx_stop2 || r_tx_stop_cnt)) w_tx_next = ST_IDLE;
      default:   w_tx_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_state    <= ST_IDLE;
      r_tx_shift    <= '0;
      r_tx_bit      <= '0;
      r_tx_bits     <= '0;
      r_tx_par_en   <= 1'b0;
      r_tx_par      <= 1'b0;
      r_tx_stop2    <= 1'b0;
      r_tx_stop_cnt <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      if (w_tx_accept) begin
        r_tx_shift    <= tx_data_i;
        r_tx_bit      <= '0;
        r_tx_bits     <= data_bits_i;
        r_tx_par_en   <= par_en(parity_i);
        r_tx_par      <= (^(tx_data_i & bits_mask(data_bits_i))) ^ (parity_i == PAR_ODD);
        r_tx_stop2    <= stop2_i;
        r_tx_stop_cnt <= 1'b0;
      end else if (w_tx_end) begin
        if (r_tx_state == ST_DATA) begin
          r_tx_shift <= {1'b0, r_tx_shift[7:1]};
          r_tx_bit   <= r_tx_bit + 4'd1;
        end
        if (r_tx_state == ST_STOP) r_tx_stop_cnt <= 1'b1;
      end
    end
  end

  uart_state_e            r_rx_state, w_rx_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_prev, r_rx_par, r_rx_valid, r_rx_perr, r_rx_ferr;
  logic [7:0]             r_rx_shift, r_rx_data, w_rx_aligned;
  logic [3:0]             r_rx_bit, w_rx_last_bit;
  logic [1:0]             r_rx_bits, r_rx_par_mode;
  logic                   w_rx, w_rx_fall, w_rx_mid, w_rx_end;

  assign w_rx            = r_sync[SYNC_STAGES-1];
  assign w_rx_fall       = r_rx_prev && !w_rx;
  assign w_rx_last_bit   = bits_num(r_rx_bits) - 4'd1;
  assign w_rx_aligned    = rx_align(r_rx_shift, r_rx_bits);
  assign rx_valid_o      = r_rx_valid;
  assign rx_data_o       = r_rx_data;
  assign rx_parity_err_o = r_rx_perr;
  assign rx_frame_err_o  = r_rx_ferr;

  uart_bit_timer #(.CNT_BITWIDTH(CNT_BITWIDTH)) u_rx_timer (
    .i_clk  (clk_i),
    .i_rst  (rst_i),
    .i_load ((r_rx_state == ST_IDLE) && w_rx_fall),
    .i_run  (r_rx_state != ST_IDLE),
    .i_div  (div_i),
    .o_mid  (w_rx_mid),
    .o_end  (w_rx_end)
  );

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      ST_IDLE:   if (w_rx_fall) w_rx_next = ST_START;
      ST_START: begin
        if (w_rx_mid && w_rx) w_rx_next = ST_IDLE;
        else if (w_rx_end)    w_rx_next = ST_DATA;
      end
      ST_DATA:   if (w_rx_end && (r_rx_bit == w_rx_last_bit))
                   w_rx_next = par_en(r_rx_par_mode) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_rx_end) w_rx_next = ST_STOP;
      ST_STOP:   if (w_rx_mid) w_rx_next = ST_IDLE;
      default:   w_rx_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync        <= '1;
      r_rx_prev     <= 1'b1;
      r_rx_state    <= ST_IDLE;
      r_rx_valid    <= 1'b0;
      r_rx_data     <= '0;
      r_rx_perr     <= 1'b0;
      r_rx_ferr     <= 1'b0;
      r_rx_shift    <= '0;
      r_rx_bit      <= '0;
      r_rx_bits     <= '0;
      r_rx_par_mode <= '0;
      r_rx_par      <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], uart_rx_i};
      r_rx_prev  <= w_rx;
      r_rx_state <= w_rx_next;
      r_rx_valid <= 1'b0;
      case (r_rx_state)
        ST_IDLE: if (w_rx_fall) begin
          r_rx_bits     <= data_bits_i;
          r_rx_par_mode <= parity_i;
          r_rx_bit      <= '0;
        end
        ST_DATA: begin
          if (w_rx_mid) r_rx_shift <= {w_rx, r_rx_shift[7:1]};
          if (w_rx_end) r_rx_bit   <= r_rx_bit + 4'd1;
        end
        ST_PARITY: if (w_rx_mid) r_rx_par <= w_rx;
        ST_STOP: if (w_rx_mid) begin
          r_rx_valid <= 1'b1;
          r_rx_data  <= w_rx_aligned;
          r_rx_perr  <= par_en(r_rx_par_mode) &&
                        (r_rx_par ^ (^w_rx_aligned) ^ (r_rx_par_mode == PAR_ODD));
          r_rx_ferr  <= !w_rx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cfg_if.sv
// Scoreboard bench: directed TX/RX frames, expected RX results queued and checked by a monitor.
module tb_uart_cfg_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] div;
  logic [1:0]  data_bits, parity;
  logic        stop2, rts, hold, tx_valid;
  logic [7:0]  tx_data;
  logic        cts, uart_tx, rx_valid, perr, ferr, tx_ready;
  logic [7:0]  rx_data;
  logic        loop_en, rx_bb;
  logic        uart_rx;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rx_exp_t;

  rx_exp_t q[$];
  int      n_checks = 0;
  int      n_pass   = 0;
  int      n_rx_seen = 0;

  always #5 clk = ~clk;
  assign uart_rx = loop_en ? uart_tx : rx_bb;

  uart_cfg_if #(.CNT_BITWIDTH(16), .SYNC_STAGES(2)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .div_i           (div),
    .data_bits_i     (data_bits),
    .parity_i        (parity),
    .stop2_i         (stop2),
    .uart_rx_i       (uart_rx),
    .uart_cts_o      (cts),
    .uart_tx_o       (uart_tx),
    .uart_rts_i      (rts),
    .rx_valid_o      (rx_valid),
    .rx_data_o       (rx_data),
    .rx_parity_err_o (perr),
    .rx_frame_err_o  (ferr),
    .rx_hold_i       (hold),
    .tx_valid_i      (tx_valid),
    .tx_data_i       (tx_data),
    .tx_ready_o      (tx_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every rx_valid_o pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      rx_exp_t e;
      n_rx_seen++;
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL rx_unexpected: got data %0h perr %0b ferr %0b, no frame expected", rx_data, perr, ferr);
      end else begin
        e = q.pop_front();
        chk("rx_data", rx_data, e.d);
        chk("rx_parity_err", perr, e.pe);
        chk("rx_frame_err", ferr, e.fe);
      end
    end
  end

  // Accept one TX byte and follow the frame; len = frame length in clocks.
  task automatic frame_run(input logic [7:0] d, input int len, input int par_idx, input logic par_exp);
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    for (int j = 1; j <= len + 1; j++) begin
      @(negedge clk);
      if (j == 1)       chk("tx_start_low", uart_tx, 1'b0);
      if (j == par_idx) chk("tx_parity_bit", uart_tx, par_exp);
      if (j == len)     chk("tx_ready_in_frame", tx_ready, 1'b0);
      if (j == len + 1) chk("tx_ready_after_frame", tx_ready, 1'b1);
    end
  endtask

  // Bit-bang n bits (LSB first) on the RX line, d clocks each, then idle high.
  task automatic bb_bits(input logic [15:0] bits, input int n, input int d);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_bb = bits[i];
      repeat (d - 1) @(posedge clk);
    end
    @(posedge clk); #1;
    rx_bb = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] wav;
    int         seen;

    rst = 1'b1; div = 16'd8; data_bits = 2'b11; parity = 2'b00; stop2 = 1'b0;
    rts = 1'b1; hold = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    loop_en = 1'b1; rx_bb = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx_line", uart_tx, 1'b1);
    chk("reset_tx_ready", tx_ready, 1'b0);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_perr", perr, 1'b0);
    chk("reset_ferr", ferr, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", tx_ready, 1'b1);
    chk("cts_hold0", cts, 1'b1);
    hold = 1'b1;
    @(negedge clk);
    chk("cts_hold1", cts, 1'b0);
    hold = 1'b0;

    // 8N1 div 8, 0xA5: line 0,1,0,1,0,0,1,0,1,1, each 8 clocks
    wav = 10'b11_0100_1010;
    q.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0});
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        chk($sformatf("tx_8n1_bit%0d", b), uart_tx, wav[b]);
      end
    end
    chk("tx_8n1_ready_low_last", tx_ready, 1'b0);
    @(negedge clk);
    chk("tx_8n1_ready_after_80", tx_ready, 1'b1);
    repeat (20) @(posedge clk);

    // 7E2 div 16: parity of 0x35 (7 bits) is 0; 0xB5 masks to 0x35
    div = 16'd16; data_bits = 2'b10; parity = 2'b01; stop2 = 1'b1;
    q.push_back('{d: 8'h35, pe: 1'b0, fe: 1'b0});
    frame_run(8'h35, 176, 137, 1'b0);
    q.push_back('{d: 8'h35, pe: 1'b0, fe: 1'b0});
    frame_run(8'hB5, 176, 137, 1'b0);
    repeat (20) @(posedge clk);

    // 8O1 div 8, 0x01: odd parity bit is 0
    div = 16'd8; data_bits = 2'b11; parity = 2'b10; stop2 = 1'b0;
    q.push_back('{d: 8'h01, pe: 1'b0, fe: 1'b0});
    frame_run(8'h01, 88, 76, 1'b0);
    repeat (20) @(posedge clk);

    // False start then a valid 0x5A, 8N1 div 16, bit-banged
    loop_en = 1'b0; rx_bb = 1'b1;
    div = 16'd16; data_bits = 2'b11; parity = 2'b00; stop2 = 1'b0;
    repeat (5) @(posedge clk);
    seen = n_rx_seen;
    @(posedge clk); #1;
    rx_bb = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_bb = 1'b1;
    repeat (40) @(posedge clk);
    chk("false_start_no_valid", n_rx_seen, seen);
    q.push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b0});
    bb_bits({6'b0, 1'b1, 8'h5A, 1'b0}, 10, 16);
    repeat (30) @(posedge clk);
    chk("false_start_then_frame", n_rx_seen, seen + 1);

    // Odd parity, 0x00 with parity 0 and stop 0: both errors
    parity = 2'b10;
    q.push_back('{d: 8'h00, pe: 1'b1, fe: 1'b1});
    bb_bits(16'h0000, 11, 16);
    repeat (30) @(posedge clk);
    chk("rx_data_held", rx_data, 8'h00);
    chk("rx_ferr_held", ferr, 1'b1);

    // Flow control: rts low blocks, rts high accepts, rts low mid-frame doesn't abort
    loop_en = 1'b1;
    div = 16'd8; data_bits = 2'b11; parity = 2'b00; stop2 = 1'b0;
    repeat (5) @(posedge clk);
    #1 rts = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rts0_ready_low", tx_ready, 1'b0);
      chk("rts0_line_idle", uart_tx, 1'b1);
    end
    @(posedge clk); #1;
    rts = 1'b1;
    @(negedge clk);
    chk("rts1_ready_same_cycle", tx_ready, 1'b1);
    q.push_back('{d: 8'hC3, pe: 1'b0, fe: 1'b0});
    @(posedge clk); #1;
    tx_valid = 1'b0;
    @(negedge clk);
    chk("rts_frame_started", uart_tx, 1'b0);
    repeat (20) @(posedge clk);
    #1 rts = 1'b0;
    repeat (70) @(posedge clk);
    @(negedge clk);
    chk("rts0_frame_done_line", uart_tx, 1'b1);
    chk("rts0_ready_after_frame", tx_ready, 1'b0);
    rts = 1'b1;
    #1;
    chk("rts1_ready_idle", tx_ready, 1'b1);

    // Reset during data bit 3 of 0x00
    @(posedge clk); #1;
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (36) @(negedge clk);
    chk("tx_bit3_low", uart_tx, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_reset_tx_high", uart_tx, 1'b1);
    chk("mid_reset_ready_low", tx_ready, 1'b0);
    chk("mid_reset_rx_data", rx_data, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_mid_reset", tx_ready, 1'b1);

    repeat (100) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
